// File: rtl/seq_code_lock.sv
// seq_code_lock: sequence-code detector with loadable code,
// per-press timeout and lockout after repeated failures.
//
// Ports:
//   Clk, Rst_n        clock (rising edge), async active-low reset
//   S                 arm / restart entry
//   Btn[NUM_BTN]      raw button levels
//   CodeLd            write CodeVal into code[CodeIdx] (IDLE only)
//   CodeIdx, CodeVal  code element index / button index
//   U, Fail           one-cycle unlock / failure pulses
//   Locked            high during lockout
//   Busy              high while a code is being entered
module seq_code_lock #(
  parameter int NUM_BTN  = 4,
  parameter int CODE_LEN = 4,
  parameter logic [CODE_LEN*$clog2(NUM_BTN)-1:0]
    RST_CODE = 8'h18,
  parameter int TIMEOUT  = 255,
  parameter int MAX_FAIL = 3,
  parameter int LOCK_CYC = 1000,
  localparam int W = $clog2(NUM_BTN),
  localparam int K = (CODE_LEN > 1) ?
                     $clog2(CODE_LEN) : 1
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               S,
  input  logic [NUM_BTN-1:0] Btn,
  input  logic               CodeLd,
  input  logic [K-1:0]       CodeIdx,
  input  logic [W-1:0]       CodeVal,
  output logic               U,
  output logic               Fail,
  output logic               Locked,
  output logic               Busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int LW = $clog2(LOCK_CYC + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);

  localparam logic [K-1:0]  K_LAST =
    K'(CODE_LEN - 1);
  localparam logic [TW-1:0] T_LAST =
    TW'(TIMEOUT - 1);
  localparam logic [LW-1:0] L_LAST =
    LW'(LOCK_CYC - 1);
  localparam logic [FW-1:0] F_MAX =
    FW'(MAX_FAIL);

  typedef enum logic [1:0] {
    IDLE,
    ENTER,
    LOCKOUT
  } state_t;

  state_t state_q, state_d;

  logic [K-1:0]       k_q, k_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic [LW-1:0]      lck_q, lck_d;
  logic [FW-1:0]      fcnt_q, fcnt_d;
  logic [NUM_BTN-1:0] btn_q;
  logic [W-1:0]       code_q [CODE_LEN];

  logic         u_d, fail_d, fail_ev;
  logic         press, hit, code_wr;
  logic [W-1:0] btn_idx;

  // A press is the first cycle any button is
  // down after all buttons were released.
  assign press = (|Btn) & ~(|btn_q);

  assign code_wr = (state_q == IDLE) && CodeLd &&
                   (int'(CodeIdx) < CODE_LEN) &&
                   (int'(CodeVal) < NUM_BTN);

  always_comb begin
    btn_idx = '0;
    for (int i = 0; i < NUM_BTN; i++)
      if (Btn[i]) btn_idx = W'(i);
  end

  assign hit = $onehot(Btn) &&
               (btn_idx == code_q[k_q]);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    tmr_d   = tmr_q;
    lck_d   = lck_q;
    fcnt_d  = fcnt_q;
    u_d     = 1'b0;
    fail_d  = 1'b0;
    fail_ev = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (S) begin
          state_d = ENTER;
          k_d     = '0;
          tmr_d   = '0;
        end
      end
      ENTER: begin
        if (S) begin
          k_d   = '0;
          tmr_d = '0;
        end else if (press && hit) begin
          if (k_q == K_LAST) begin
            u_d     = 1'b1;
            fcnt_d  = '0;
            state_d = IDLE;
          end else begin
            k_d   = k_q + 1'b1;
            tmr_d = '0;
          end
        end else if (press) begin
          fail_ev = 1'b1;
        end else if (tmr_q == T_LAST) begin
          fail_ev = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      LOCKOUT: begin
        if (lck_q == L_LAST) begin
          lck_d   = '0;
          fcnt_d  = '0;
          state_d = IDLE;
        end else begin
          lck_d = lck_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fail_ev) begin
      fail_d = 1'b1;
      fcnt_d = (fcnt_q == F_MAX) ?
               fcnt_q : fcnt_q + 1'b1;
      if (fcnt_d == F_MAX) begin
        state_d = LOCKOUT;
        lck_d   = '0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      tmr_q   <= '0;
      lck_q   <= '0;
      fcnt_q  <= '0;
      btn_q   <= '0;
      U       <= 1'b0;
      Fail    <= 1'b0;
      Locked  <= 1'b0;
      Busy    <= 1'b0;
      for (int i = 0; i < CODE_LEN; i++)
        code_q[i] <= RST_CODE[i*W +: W];
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      tmr_q   <= tmr_d;
      lck_q   <= lck_d;
      fcnt_q  <= fcnt_d;
      btn_q   <= Btn;
      U       <= u_d;
      Fail    <= fail_d;
      Locked  <= (state_d == LOCKOUT);
      Busy    <= (state_d == ENTER);
      if (code_wr)
        code_q[CodeIdx] <= CodeVal;
    end
  end

endmodule

// File: tb/tb_seq_code_lock.sv
// tb_seq_code_lock: directed bench with a
// sequence-level reference model.
module tb_seq_code_lock;

  localparam int NB = 4;
  localparam int CL = 4;
  localparam int TO = 12;
  localparam int MF = 3;
  localparam int LC = 1000;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       S = 1'b0;
  logic [3:0] Btn = '0;
  logic       CodeLd = 1'b0;
  logic [1:0] CodeIdx = '0;
  logic [1:0] CodeVal = '0;
  logic       U, Fail, Locked, Busy;

  int total = 0;
  int bad = 0;
  int u_cnt = 0;
  int f_cnt = 0;
  int lk_cyc = 0;

  always #5 Clk = ~Clk;

  seq_code_lock #(
    .NUM_BTN (NB),
    .CODE_LEN(CL),
    .TIMEOUT (TO),
    .MAX_FAIL(MF),
    .LOCK_CYC(LC)
  ) dut (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .S      (S),
    .Btn    (Btn),
    .CodeLd (CodeLd),
    .CodeIdx(CodeIdx),
    .CodeVal(CodeVal),
    .U      (U),
    .Fail   (Fail),
    .Locked (Locked),
    .Busy   (Busy)
  );

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 entering,
  // 2 locked out. Entered digits kept in a queue.
  int   mode;
  int   mfails;
  int   mleft;
  int   midle;
  int   mcode [CL];
  int   entered [$];
  logic [3:0] mprev;
  logic e_u, e_f, e_l, e_b;

  task automatic m_reset();
    mode = 0;
    mfails = 0;
    mleft = 0;
    midle = 0;
    entered.delete();
    mprev = '0;
    mcode[0] = 0;
    mcode[1] = 2;
    mcode[2] = 1;
    mcode[3] = 0;
    e_u = 0;
    e_f = 0;
    e_l = 0;
    e_b = 0;
  endtask

  task automatic m_fail();
    e_f = 1;
    if (mfails < MF) mfails++;
    if (mfails >= MF) begin
      mode = 2;
      mleft = LC;
    end else begin
      mode = 0;
    end
  endtask

  task automatic m_step();
    bit pr;
    int bi;
    pr = (Btn != 0) && (mprev == 0);
    bi = $clog2(Btn);
    e_u = 0;
    e_f = 0;
    if (mode == 2) begin
      mleft--;
      if (mleft == 0) begin
        mode = 0;
        mfails = 0;
      end
    end else if (mode == 0) begin
      if (CodeLd && CodeIdx < CL && CodeVal < NB)
        mcode[CodeIdx] = int'(CodeVal);
      if (S) begin
        mode = 1;
        entered.delete();
        midle = 0;
      end
    end else begin
      if (S) begin
        entered.delete();
        midle = 0;
      end else if (pr) begin
        if ($countones(Btn) == 1 &&
            bi == mcode[entered.size()]) begin
          entered.push_back(bi);
          midle = 0;
          if (entered.size() == CL) begin
            e_u = 1;
            mfails = 0;
            mode = 0;
          end
        end else begin
          m_fail();
        end
      end else begin
        midle++;
        if (midle == TO) m_fail();
      end
    end
    mprev = Btn;
    e_l = (mode == 2);
    e_b = (mode == 1);
  endtask

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) m_reset();
    else m_step();
  end

  always @(negedge Clk) begin
    chk("U", int'(U), int'(e_u));
    chk("Fail", int'(Fail), int'(e_f));
    chk("Locked", int'(Locked), int'(e_l));
    chk("Busy", int'(Busy), int'(e_b));
    if (U === 1'b1) u_cnt++;
    if (Fail === 1'b1) f_cnt++;
    if (Locked === 1'b1) lk_cyc++;
  end

  task automatic cyc(logic s, logic [3:0] b);
    S = s;
    Btn = b;
    @(negedge Clk);
    #1;
  endtask

  task automatic press(int i);
    cyc(1'b0, 4'(1 << i));
    cyc(1'b0, 4'd0);
  endtask

  task automatic arm();
    cyc(1'b1, 4'd0);
  endtask

  task automatic code4(int a, int b, int c, int d);
    press(a);
    press(b);
    press(c);
    press(d);
  endtask

  task automatic load(int i, int v);
    CodeLd = 1'b1;
    CodeIdx = 2'(i);
    CodeVal = 2'(v);
    cyc(1'b0, 4'd0);
    CodeLd = 1'b0;
  endtask

  initial begin
    int u0, f0, l0, n;
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    #1;
    chk("rst_U", int'(U), 0);
    chk("rst_Fail", int'(Fail), 0);
    chk("rst_Locked", int'(Locked), 0);
    chk("rst_Busy", int'(Busy), 0);
    Rst_n = 1'b1;
    cyc(1'b0, 4'd0);

    // T1 reset code R,B,G,R
    u0 = u_cnt;
    f0 = f_cnt;
    arm();
    chk("t1_busy", int'(Busy), 1);
    code4(0, 2, 1, 0);
    chk("t1_u", u_cnt - u0, 1);
    chk("t1_f", f_cnt - f0, 0);
    chk("t1_idle", int'(Busy), 0);

    // T2 wrong second press
    f0 = f_cnt;
    arm();
    press(0);
    press(1);
    chk("t2_f", f_cnt - f0, 1);
    chk("t2_busy", int'(Busy), 0);
    u0 = u_cnt;
    arm();
    code4(0, 2, 1, 0);
    chk("t2_u", u_cnt - u0, 1);

    // T3 held button and multi-hot press
    u0 = u_cnt;
    f0 = f_cnt;
    arm();
    repeat (10) cyc(1'b0, 4'b0001);
    cyc(1'b0, 4'd0);
    press(2);
    press(1);
    press(0);
    chk("t3_u", u_cnt - u0, 1);
    chk("t3_f", f_cnt - f0, 0);
    f0 = f_cnt;
    arm();
    cyc(1'b0, 4'b0101);
    cyc(1'b0, 4'd0);
    chk("t3_multi", f_cnt - f0, 1);
    arm();
    code4(0, 2, 1, 0);

    // T4 lockout
    f0 = f_cnt;
    l0 = lk_cyc;
    repeat (3) begin
      arm();
      press(1);
    end
    chk("t4_f", f_cnt - f0, 3);
    chk("t4_locked", int'(Locked), 1);
    u0 = u_cnt;
    arm();
    code4(0, 2, 1, 0);
    chk("t4_ign_u", u_cnt - u0, 0);
    chk("t4_ign_busy", int'(Busy), 0);
    n = 0;
    while (Locked === 1'b1 && n < 1100) begin
      cyc(1'b0, 4'd0);
      n++;
    end
    chk("t4_unlock", int'(Locked), 0);
    chk("t4_lock_len", lk_cyc - l0, LC);
    u0 = u_cnt;
    arm();
    code4(0, 2, 1, 0);
    chk("t4_u", u_cnt - u0, 1);

    // T5 timeout, then restart mid-entry
    f0 = f_cnt;
    arm();
    press(0);
    repeat (10) cyc(1'b0, 4'd0);
    chk("t5_nofail", f_cnt - f0, 0);
    chk("t5_busy", int'(Busy), 1);
    cyc(1'b0, 4'd0);
    chk("t5_to", f_cnt - f0, 1);
    chk("t5_idle", int'(Busy), 0);
    f0 = f_cnt;
    u0 = u_cnt;
    arm();
    press(0);
    press(2);
    arm();
    chk("t5_rbusy", int'(Busy), 1);
    code4(0, 2, 1, 0);
    chk("t5_rf", f_cnt - f0, 0);
    chk("t5_ru", u_cnt - u0, 1);

    // T6 loadable code
    load(0, 1);
    load(1, 1);
    load(2, 2);
    load(3, 0);
    u0 = u_cnt;
    arm();
    code4(1, 1, 2, 0);
    chk("t6_new", u_cnt - u0, 1);
    f0 = f_cnt;
    arm();
    press(0);
    chk("t6_old", f_cnt - f0, 1);
    u0 = u_cnt;
    arm();
    load(0, 3);
    code4(1, 1, 2, 0);
    chk("t6_ld_ign", u_cnt - u0, 1);
    arm();
    press(1);
    Rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", int'(Busy), 0);
    chk("t6_rst_u", int'(U), 0);
    chk("t6_rst_f", int'(Fail), 0);
    chk("t6_rst_l", int'(Locked), 0);
    cyc(1'b0, 4'd0);
    Rst_n = 1'b1;
    cyc(1'b0, 4'd0);
    u0 = u_cnt;
    arm();
    code4(0, 2, 1, 0);
    chk("t6_rstcode", u_cnt - u0, 1);

    cyc(1'b0, 4'd0);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
